adc_sampler: RTL and testbench
==============================

Name: adc_sampler

Overview:
Upstream stage for the ADC0/ADC1 sample queues. It drives an external 2-channel 10-bit SPI ADC (MCP3002 framing) at the sample rate set by the prescaler `pre`. It loads each 10-bit result into the matching ADC queue using a one-cycle load strobe. The channel enables come from the `activemods` ADC bits produced by the control block.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (>=2)
TICK_DIV, 100, clk cycles per prescaler unit
PRE_W, 10, prescaler width
DATA_W, 10, sample width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
pre  in  PRE_W  sample period = (pre+1)*TICK_DIV clk cycles
en  in  2  channel enables [ch1,ch0]
clr_flags  in  1  synchronous clear of ovr and drop
sclk  out  1  SPI clock, idle low
cs_n  out  1  ADC chip select, active-low
mosi  out  1  ADC command bit
miso  in  1  ADC data bit
out_adc0  out  DATA_W  ADC0 queue data
ld_adc0  out  1  ADC0 queue load strobe
full_adc0  in  1  ADC0 queue full
out_adc1  out  DATA_W  ADC1 queue data
ld_adc1  out  1  ADC1 queue load strobe
full_adc1  in  1  ADC1 queue full
ovr  out  1  sticky: a tick arrived while a frame was in progress
drop  out  1  sticky: a sample was discarded because its queue was full
busy  out  1  high from the first cs_n fall to the last push

Behaviour:
- Reset values: sclk=0, cs_n=1, mosi=0, ld_*=0, out_*=0, ovr=0, drop=0, busy=0.
- Reset also clears the prescaler counter and returns the FSM to IDLE, even mid-frame. No partial push occurs.
- Tick generator:
  - Counts clk cycles.
  - One-cycle tick when count >= (pre+1)*TICK_DIV-1, then count restarts at 0.
  - The `>=` compare makes a mid-count decrease of pre take effect on the current period.
  - Ticks run regardless of en.
- On a tick in IDLE with en!=0:
  - Latch en into chset; later changes to en do not affect this burst.
  - Start with ch0 if chset[0] is set, else ch1.
- On a tick when the FSM is not IDLE: set ovr. The tick is otherwise ignored.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> PUSH -> (GAP -> SETUP for ch1 | IDLE).
- SETUP (CLK_DIV cycles): cs_n=0, sclk=0, mosi carries command bit 0.
- SHIFT: 16 SCLK periods, each CLK_DIV low then CLK_DIV high.
  - mosi changes on sclk falling edges.
  - miso is sampled on the clk cycle in which sclk rises.
  - Command bits 0..3: 1 (start), 1 (single-ended), ch, 1 (MSB-first); mosi=0 afterwards.
  - Bit 4 is the null bit.
  - Bits 5..14 are D9..D0, shifted MSB-first.
  - Bit 15 is ignored.
- HOLD: sclk=0; cs_n goes 1 after CLK_DIV cycles.
- PUSH: one cycle.
  - If the queue is not full: out_adcN=sample and ld_adcN=1 for exactly one cycle.
  - If the queue is full: no ld, drop set.
  - out_adcN holds its value until the next push on that channel.
- GAP: cs_n=1 for CLK_DIV cycles before the ch1 frame.
- Latency: from the tick cycle T, ld is asserted at T+1+CLK_DIV*34.
- Flags: if clr_flags and a set event occur in the same cycle, set wins.
- ld_adc0 and ld_adc1 are never asserted in the same cycle.

Decomposition:
- Shared package adc_pkg:
  - FRAME_BITS=16, CMD_BITS=4, DATA_LSB_IDX=14.
  - Command-bit constants.
  - FSM state enum.
- Sub-module adc_tick_gen: the prescaler counter. Parameters TICK_DIV and PRE_W; ports clk, rst_n, pre, tick.

Test Plan:
- Reset: hold rst_n=0 -> sclk=0, cs_n=1, ld_*=0, ovr=0, drop=0. Release -> first tick at cycle (pre+1)*TICK_DIV.
- Single channel (CLK_DIV=2, TICK_DIV=8, pre=15, en=01, ADC model returns 0x2A5):
  - mosi bits are 1,1,0,1.
  - One ld_adc0 pulse with out_adc0=0x2A5, 69 cycles after the tick.
  - Period is 128 cycles; ovr stays 0.
- Both channels (en=11, model ch0=0x001, ch1=0x3FF):
  - ld_adc0 (0x001) first, then ld_adc1 (0x3FF).
  - Third command bit is 0 then 1.
  - cs_n high for >=2 cycles between the two frames.
- Full queue: full_adc0=1 during the ch0 PUSH with en=11 -> no ld_adc0, drop=1, ld_adc1 still pulses. A clr_flags pulse then sets drop=0.
- Overrun: pre=0, TICK_DIV=8, en=01 -> ovr=1 at the second tick. Samples continue at one per completed frame.
- Reset mid-SHIFT: rst_n=0 at SCLK period 8 -> cs_n=1 asynchronously, no ld pulse. After release, the next tick starts a clean frame.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and MCP3002 command-bit helper for the ADC sampler.
package adc_pkg;

  localparam int unsigned FRAME_BITS    = 16;
  localparam int unsigned CMD_BITS      = 4;
  localparam int unsigned DATA_MSB_IDX  = 5;
  localparam int unsigned DATA_LSB_IDX  = 14;

  localparam logic CMD_START  = 1'b1;
  localparam logic CMD_SGL    = 1'b1;
  localparam logic CMD_MSBF   = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StPush,
    StGap
  } adc_state_e;

  // Command bit driven on mosi during frame bit idx for channel ch.
  function automatic logic cmd_bit(logic [3:0] idx, logic ch);
    logic b;
    case (idx)
      4'd0:    b = CMD_START;
      4'd1:    b = CMD_SGL;
      4'd2:    b = ch;
      4'd3:    b = CMD_MSBF;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_sampler_if.sv
// SPI ADC pins plus the two ADC queue load ports; master is the sampler side.
interface adc_sampler_if #(
  parameter int unsigned DATA_W = 10
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] out_adc0;
  logic              ld_adc0;
  logic              full_adc0;
  logic [DATA_W-1:0] out_adc1;
  logic              ld_adc1;
  logic              full_adc1;

  modport master (
    output sclk, cs_n, mosi, out_adc0, ld_adc0, out_adc1, ld_adc1,
    input  miso, full_adc0, full_adc1
  );

  modport slave (
    input  sclk, cs_n, mosi, out_adc0, ld_adc0, out_adc1, ld_adc1,
    output miso, full_adc0, full_adc1
  );
endinterface

// File: rtl/adc_tick_gen.sv
// Prescaler: one-cycle tick every (pre+1)*TICK_DIV clk cycles.
module adc_tick_gen #(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned PRE_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  localparam int unsigned CntW = PRE_W + $clog2(TICK_DIV) + 1;

  logic [CntW-1:0] cnt_q, cnt_d, limit;

  // >= so that lowering pre mid-period shortens the current period.
  always_comb begin
    limit = (CntW'(pre) + CntW'(1)) * CntW'(TICK_DIV) - CntW'(1);
    tick  = (cnt_q >= limit);
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_sampler.sv
// Drives an MCP3002-style SPI ADC once per prescaler tick and loads results into
// the ADC0/ADC1 queues with one-cycle strobes.
module adc_sampler
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned PRE_W    = 10,
  parameter int unsigned DATA_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PRE_W-1:0] pre,
  input  logic [1:0]       en,
  input  logic             clr_flags,
  adc_sampler_if.master    bus,
  output logic             ovr,
  output logic             drop,
  output logic             busy
);

  localparam int unsigned DivW = $clog2(CLK_DIV);

  adc_state_e        state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              hi_q, hi_d;
  logic [3:0]        bit_q, bit_d;
  logic [1:0]        chset_q, chset_d;
  logic              ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d, out0_q, out0_d, out1_q, out1_d;
  logic              sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
  logic              ld0_q, ld0_d, ld1_q, ld1_d;
  logic              ovr_q, ovr_d, drop_q, drop_d, busy_q, busy_d;
  logic              tick, div_last, q_full, drop_set;

  adc_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .PRE_W    (PRE_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .pre   (pre),
    .tick  (tick)
  );

  assign div_last = (div_q == DivW'(CLK_DIV - 1));
  assign q_full   = ch_q ? bus.full_adc1 : bus.full_adc0;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    hi_d     = hi_q;
    bit_d    = bit_q;
    chset_d  = chset_q;
    ch_d     = ch_q;
    data_d   = data_q;
    out0_d   = out0_q;
    out1_d   = out1_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ld0_d    = 1'b0;
    ld1_d    = 1'b0;
    drop_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick && en != 2'b00) begin
          chset_d = en;
          ch_d    = ~en[0];
          state_d = StSetup;
          div_d   = '0;
          sclk_d  = 1'b0;
          mosi_d  = cmd_bit(4'd0, ~en[0]);
        end
      end
      StSetup: begin
        if (div_last) begin
          state_d = StShift;
          div_d   = '0;
          hi_d    = 1'b0;
          bit_d   = '0;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StShift: begin
        // First cycle with sclk high: capture D9..D0.
        if (hi_q && div_q == '0 && bit_q >= 4'(DATA_MSB_IDX) && bit_q <= 4'(DATA_LSB_IDX)) begin
          data_d = {data_q[DATA_W-2:0], bus.miso};
        end
        if (!div_last) begin
          div_d = div_q + DivW'(1);
        end else begin
          div_d = '0;
          if (!hi_q) begin
            hi_d   = 1'b1;
            sclk_d = 1'b1;
          end else if (bit_q == 4'(FRAME_BITS - 1)) begin
            state_d = StHold;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
          end else begin
            hi_d   = 1'b0;
            sclk_d = 1'b0;
            bit_d  = bit_q + 4'd1;
            mosi_d = cmd_bit(bit_q + 4'd1, ch_q);
          end
        end
      end
      StHold: begin
        if (div_last) begin
          state_d = StPush;
          if (q_full) begin
            drop_set = 1'b1;
          end else if (ch_q) begin
            ld1_d  = 1'b1;
            out1_d = data_q;
          end else begin
            ld0_d  = 1'b1;
            out0_d = data_q;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StPush: begin
        div_d = '0;
        if ((&chset_q) && !ch_q) begin
          state_d = StGap;
          ch_d    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (div_last) begin
          state_d = StSetup;
          div_d   = '0;
          mosi_d  = cmd_bit(4'd0, ch_q);
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    cs_n_d = (state_d inside {StIdle, StPush, StGap});
    busy_d = (state_d != StIdle);
    ovr_d  = (tick && state_q != StIdle) || (ovr_q && !clr_flags);
    drop_d = drop_set || (drop_q && !clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      chset_q <= '0;
      ch_q    <= 1'b0;
      data_q  <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ld0_q   <= 1'b0;
      ld1_q   <= 1'b0;
      ovr_q   <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      bit_q   <= bit_d;
      chset_q <= chset_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      ld0_q   <= ld0_d;
      ld1_q   <= ld1_d;
      ovr_q   <= ovr_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.mosi     = mosi_q;
  assign bus.out_adc0 = out0_q;
  assign bus.ld_adc0  = ld0_q;
  assign bus.out_adc1 = out1_q;
  assign bus.ld_adc1  = ld1_q;
  assign ovr          = ovr_q;
  assign drop         = drop_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: behavioural ADC device, timeline reference model, directed and
// random phases.
module tb_adc_sampler;

  localparam int unsigned CD = 2;
  localparam int unsigned TD = 8;
  localparam int unsigned PW = 10;
  localparam int unsigned DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [PW-1:0] pre;
  logic [1:0]    en;
  logic          clr;
  logic          ovr, drop, busy;

  adc_sampler_if #(.DATA_W(DW)) bus ();

  adc_sampler #(
    .CLK_DIV  (CD),
    .TICK_DIV (TD),
    .PRE_W    (PW),
    .DATA_W   (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pre       (pre),
    .en        (en),
    .clr_flags (clr),
    .bus       (bus),
    .ovr       (ovr),
    .drop      (drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural ADC: shifts out the value of the commanded channel, junk on don't-care bits.
  logic [DW-1:0] adc_val[2];
  int            bitn = 0;
  logic [3:0]    cmd;
  int            ch_exp_q[$];
  int            cyc = 0;
  int            rise_cyc = -1;

  always @(negedge bus.cs_n) begin
    bitn     = 0;
    cmd      = '0;
    bus.miso = 1'($urandom);
    if (rise_cyc >= 0) check("cs_gap", 32'(cyc - rise_cyc >= 2), 32'd1);
  end

  always @(posedge bus.sclk) begin
    if (bitn < 4) cmd[bitn] = bus.mosi;
  end

  always @(negedge bus.sclk) begin
    bitn++;
    if (bitn >= 5 && bitn <= 14) bus.miso = adc_val[cmd[2]][14 - bitn];
    else if (bitn == 4)          bus.miso = 1'b0;
    else                         bus.miso = 1'($urandom);
  end

  always @(posedge bus.cs_n) begin
    int e;
    if (bitn == 16) begin
      e = (ch_exp_q.size() > 0) ? ch_exp_q.pop_front() : -1;
      check("cmd_bits", 32'(cmd), (e < 0) ? 32'hDEAD : 32'({1'b1, e[0], 2'b11}));
    end
    rise_cyc = cyc;
  end

  // Reference timeline: burst from tick T, ld of first frame at T+1+34*CD,
  // second channel at T+2+69*CD, busy from T+1 to the last push.
  int            tcnt, bstart, bend, ld0_at, ld1_at;
  bit            f0, f1, ovr_m, drop_m, rnd;
  logic [DW-1:0] out0_m, out1_m, v0, v1;
  logic [DW-1:0] dir_v0 = 10'h2A5, dir_v1 = 10'h3FF;
  bit            dir_f0 = 1'b0, dir_f1 = 1'b0;
  int            first_busy, c0;

  task automatic model_reset();
    tcnt   = 0;
    bstart = -1;
    bend   = -2;
    ld0_at = -1;
    ld1_at = -1;
    ovr_m  = 1'b0;
    drop_m = 1'b0;
    out0_m = '0;
    out1_m = '0;
    ch_exp_q.delete();
    rise_cyc = -1;
  endtask

  task automatic start_burst();
    if (rnd) begin
      adc_val[0] = DW'($urandom_range(0, 1023));
      adc_val[1] = DW'($urandom_range(0, 1023));
      f0 = ($urandom_range(0, 3) == 0);
      f1 = ($urandom_range(0, 3) == 0);
    end else begin
      adc_val[0] = dir_v0;
      adc_val[1] = dir_v1;
      f0 = dir_f0;
      f1 = dir_f1;
    end
    bus.full_adc0 = f0;
    bus.full_adc1 = f1;
    v0 = adc_val[0];
    v1 = adc_val[1];
    bstart = cyc + 1;
    ld0_at = -1;
    ld1_at = -1;
    if (en[0]) begin
      ld0_at = cyc + 1 + 34 * CD;
      ch_exp_q.push_back(0);
      if (en[1]) begin
        ld1_at = cyc + 2 + 69 * CD;
        ch_exp_q.push_back(1);
      end
    end else begin
      ld1_at = cyc + 1 + 34 * CD;
      ch_exp_q.push_back(1);
    end
    bend = (ld0_at > ld1_at) ? ld0_at : ld1_at;
  endtask

  // Called at a negedge; compares this cycle, drives inputs, advances model one cycle.
  task automatic step();
    bit busy_now, e0, e1, tk, s_ovr, s_drop;
    busy_now = (cyc >= bstart && cyc <= bend);
    e0 = (cyc == ld0_at) && !f0;
    e1 = (cyc == ld1_at) && !f1;
    if (e0) out0_m = v0;
    if (e1) out1_m = v1;
    check("ld_adc0", 32'(bus.ld_adc0), 32'(e0));
    check("ld_adc1", 32'(bus.ld_adc1), 32'(e1));
    check("ld_excl", 32'(bus.ld_adc0 & bus.ld_adc1), 32'd0);
    check("out_adc0", 32'(bus.out_adc0), 32'(out0_m));
    check("out_adc1", 32'(bus.out_adc1), 32'(out1_m));
    check("ovr", 32'(ovr), 32'(ovr_m));
    check("drop", 32'(drop), 32'(drop_m));
    check("busy", 32'(busy), 32'(busy_now));
    if (busy && first_busy < 0) first_busy = cyc;
    if (rnd) begin
      if ($urandom_range(0, 199) == 0) pre = PW'($urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0)  en = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 29) == 0);
    end
    tk    = (tcnt >= (int'(pre) + 1) * TD - 1);
    tcnt  = tk ? 0 : tcnt + 1;
    s_ovr = tk && busy_now;
    if (tk && !busy_now && en != 2'b00) start_burst();
    s_drop = (cyc + 1 == ld0_at && f0) || (cyc + 1 == ld1_at && f1);
    ovr_m  = s_ovr || (ovr_m && !clr);
    drop_m = s_drop || (drop_m && !clr);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int guard;
    pre = PW'(15);
    en  = 2'b01;
    clr = 1'b0;
    rnd = 1'b0;
    bus.miso = 1'b0;
    bus.full_adc0 = 1'b0;
    bus.full_adc1 = 1'b0;
    f0 = 1'b0;
    f1 = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(bus.sclk), 32'd0);
    check("rst_cs_n", 32'(bus.cs_n), 32'd1);
    check("rst_mosi", 32'(bus.mosi), 32'd0);
    check("rst_ld0", 32'(bus.ld_adc0), 32'd0);
    check("rst_ld1", 32'(bus.ld_adc1), 32'd0);
    check("rst_out0", 32'(bus.out_adc0), 32'd0);
    check("rst_out1", 32'(bus.out_adc1), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single channel, period 128, result 0x2A5
    rst_n = 1'b1;
    model_reset();
    c0 = cyc;
    first_busy = -1;
    run(2 * 128 + 90);
    check("first_tick", 32'(first_busy - c0), 32'd128);

    // Both channels
    pre = PW'(31);
    en = 2'b11;
    dir_v0 = 10'h001;
    dir_v1 = 10'h3FF;
    run(600);

    // ADC0 queue full, then clear the sticky drop while idle
    dir_f0 = 1'b1;
    run(600);
    en = 2'b00;
    dir_f0 = 1'b0;
    run(300);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    run(1);
    check("drop_clr", 32'(drop), 32'd0);

    // Overrun: ticks every 8 cycles
    pre = PW'(0);
    en = 2'b01;
    dir_v0 = 10'h155;
    run(400);

    // Reset at the start of SCLK period 8
    pre = PW'(15);
    guard = 0;
    while (cyc != bstart + CD + 16 * CD && guard < 2000) begin
      step();
      guard++;
    end
    check("shift_reach", 32'(guard < 2000), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(bus.cs_n), 32'd1);
    check("mid_rst_sclk", 32'(bus.sclk), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check("mid_rst_ld0", 32'(bus.ld_adc0), 32'd0);
      check("mid_rst_ld1", 32'(bus.ld_adc1), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    dir_v0 = 10'h0F0;
    run(400);

    // Random traffic
    rnd = 1'b1;
    run(5000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
